// File: rtl/serial_or_reducer_pkg.sv
// -----------------------------------------------------------------------------
// serial_or_reducer_pkg
// Shared types and helpers for the bit-serial OR reduction stage.
//   state_e       : frame controller states (COLLECT, HOLD)
//   MAX_FRAME_LEN : largest supported frame length
//   len_w_f()     : width needed to hold a length in 0..frame_len
// -----------------------------------------------------------------------------
package serial_or_reducer_pkg;

  localparam int unsigned MAX_FRAME_LEN = 255;

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_e;

  function automatic int unsigned len_w_f(input int unsigned frame_len);
    return $clog2(frame_len + 1);
  endfunction

endpackage

// File: rtl/serial_or_reducer_or_acc_cell.sv
// -----------------------------------------------------------------------------
// or_acc_cell
// One-bit sticky OR accumulator. Once a 1 is captured it stays set until
// cleared. Clear has priority over enable so a frame-closing bit can be
// folded into the latched result while the accumulator restarts at 0.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset (q -> 0)
//   clr_i : synchronous clear
//   en_i  : capture enable
//   d_i   : data bit
//   q_o   : accumulated OR
// -----------------------------------------------------------------------------
module or_acc_cell (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  input  logic d_i,
  output logic q_o
);

  logic acc_q;
  logic acc_d;

  // Mux between hold (q), set (1) and clear (0).
  always_comb begin
    acc_d = acc_q;
    if (clr_i) begin
      acc_d = 1'b0;
    end else if (en_i && d_i) begin
      acc_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign q_o = acc_q;

endmodule

// File: rtl/serial_or_reducer.sv
// -----------------------------------------------------------------------------
// serial_or_reducer
// Bit-serial OR reduction: single bits arrive over a valid/ready handshake,
// are grouped into frames of up to FRAME_LEN bits (or shorter when in_last
// is set on an accepted bit), and each frame yields its OR and its length.
// The result is held until downstream takes it; no input is accepted while
// a result is pending, so a frame of N bits occupies at least N+1 cycles.
//
// Optional build macro SERIAL_OR_REDUCER_ONES_EN adds out_ones, the count of
// 1 bits in the frame, latched alongside out_or.
//
// Ports:
//   clk       : clock, rising edge
//   rst_n     : asynchronous active-low reset
//   in_valid  : upstream bit valid
//   in_ready  : bit can be accepted this cycle
//   in_bit    : data bit
//   in_last   : final bit of a short frame (qualified by accept)
//   out_valid : frame result valid
//   out_ready : downstream accepts the result
//   out_or    : OR of all bits in the frame
//   out_len   : number of bits in the frame, 1..FRAME_LEN
//   out_ones  : (macro only) number of 1 bits in the frame
// -----------------------------------------------------------------------------
module serial_or_reducer
  import serial_or_reducer_pkg::*;
#(
  parameter  int unsigned FRAME_LEN = 8,
  localparam int unsigned LEN_W     = len_w_f(FRAME_LEN)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_bit,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_or,
  output logic [LEN_W-1:0] out_len
`ifdef SERIAL_OR_REDUCER_ONES_EN
  ,
  output logic [LEN_W-1:0] out_ones
`endif
);

  if (FRAME_LEN < 1 || FRAME_LEN > MAX_FRAME_LEN) begin : g_bad_frame_len
    $error("serial_or_reducer: FRAME_LEN out of range 1..255");
  end

  state_e             state_q, state_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic [LEN_W-1:0]   cnt_inc;
  logic               out_or_q, out_or_d;
  logic [LEN_W-1:0]   out_len_q, out_len_d;
  logic               acc_q;
  logic               acc_clr;
  logic               acc_en;
  logic               accept;

  assign in_ready  = (state_q == COLLECT);
  assign out_valid = (state_q == HOLD);
  assign accept    = in_valid && in_ready;
  assign cnt_inc   = cnt_q + LEN_W'(1);

  or_acc_cell u_acc (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (acc_clr),
    .en_i  (acc_en),
    .d_i   (in_bit),
    .q_o   (acc_q)
  );

`ifdef SERIAL_OR_REDUCER_ONES_EN
  logic [LEN_W-1:0] ones_q, ones_d;
  logic [LEN_W-1:0] ones_inc;
  logic [LEN_W-1:0] out_ones_q, out_ones_d;

  assign ones_inc = ones_q + LEN_W'(in_bit);
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    out_or_d  = out_or_q;
    out_len_d = out_len_q;
    acc_clr   = 1'b0;
    acc_en    = 1'b0;
`ifdef SERIAL_OR_REDUCER_ONES_EN
    ones_d     = ones_q;
    out_ones_d = out_ones_q;
`endif
    case (state_q)
      COLLECT: begin
        if (accept) begin
          acc_en = 1'b1;
          cnt_d  = cnt_inc;
`ifdef SERIAL_OR_REDUCER_ONES_EN
          ones_d = ones_inc;
`endif
          // Length limit and in_last close the same frame; either alone
          // or both together produce exactly one result.
          if (cnt_inc == LEN_W'(FRAME_LEN) || in_last) begin
            out_or_d  = acc_q | in_bit;
            out_len_d = cnt_inc;
            state_d   = HOLD;
            acc_clr   = 1'b1;
            cnt_d     = '0;
`ifdef SERIAL_OR_REDUCER_ONES_EN
            out_ones_d = ones_inc;
            ones_d     = '0;
`endif
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d = COLLECT;
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= COLLECT;
      cnt_q     <= '0;
      out_or_q  <= 1'b0;
      out_len_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      out_or_q  <= out_or_d;
      out_len_q <= out_len_d;
    end
  end

`ifdef SERIAL_OR_REDUCER_ONES_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ones_q     <= '0;
      out_ones_q <= '0;
    end else begin
      ones_q     <= ones_d;
      out_ones_q <= out_ones_d;
    end
  end

  assign out_ones = out_ones_q;
`endif

  assign out_or  = out_or_q;
  assign out_len = out_len_q;

endmodule
